// File: rtl/clock_btn_pkg.sv
// Shared constants for the push-button conditioner: default timing parameters
// and the bit position of each button in the 5-bit level/pulse vectors.
package clock_btn_pkg;

  localparam int DEF_DB_CNT       = 20000;
  localparam int DEF_REPEAT_DELAY = 50000000;
  localparam int DEF_REPEAT_RATE  = 10000000;
  localparam int DEF_LONG_CNT     = 100000000;

  localparam int NUM_BTN    = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_MIDDLE = 4;

  // One spare bit above $clog2 so a counter can sit at its terminal value
  // and still saturate without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stable-count debounce and a
// one-cycle pulse in the cycle the debounced level is loaded high.
module btn_debounce
  import clock_btn_pkg::*;
#(
  parameter int DB_CNT = DEF_DB_CNT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = cnt_width(DB_CNT);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CNT - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/button_conditioner.sv
// Five debounced push-buttons with press pulses, auto-repeat on up/down and a
// long-press event on middle. Every output comes straight from a flop.
module button_conditioner
  import clock_btn_pkg::*;
#(
  parameter int DB_CNT       = DEF_DB_CNT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int LONG_CNT     = DEF_LONG_CNT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       button_left,
  input  logic       button_right,
  input  logic       button_middle,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       middle_pulse,
  output logic       middle_long,
  output logic [4:0] btn_level
);

  localparam int HOLD_W = cnt_width(REPEAT_DELAY);
  localparam int RATE_W = cnt_width(REPEAT_RATE);
  localparam int LONG_W = cnt_width(LONG_CNT);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
  localparam logic [HOLD_W-1:0] REP_AT    = HOLD_W'(REPEAT_DELAY);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(REPEAT_RATE - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = '1;
  localparam logic [LONG_W-1:0] LONG_AT   = LONG_W'(LONG_CNT);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] db_level;
  logic [NUM_BTN-1:0] db_rise;

  assign raw[BTN_UP]     = button_up;
  assign raw[BTN_DOWN]   = button_down;
  assign raw[BTN_LEFT]   = button_left;
  assign raw[BTN_RIGHT]  = button_right;
  assign raw[BTN_MIDDLE] = button_middle;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    btn_debounce #(.DB_CNT(DB_CNT)) u_db (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .raw_i  (raw[g]),
      .level_o(db_level[g]),
      .rise_o (db_rise[g])
    );
  end

  // Hold counters track the debounced level, one cycle ahead of btn_level,
  // so a hit registered here lands on the matching btn_level-aligned count.
  logic [1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [1:0][RATE_W-1:0] rate_q, rate_d;
  logic [1:0]             rep_hit;
  logic [LONG_W-1:0]      lhold_q, lhold_d;
  logic                   long_hit;

  always_comb begin
    hold_d  = '0;
    rate_d  = '0;
    rep_hit = '0;
    for (int i = 0; i < 2; i++) begin
      rep_hit[i] = db_level[i] &&
                   ((hold_q[i] == REP_AT) ||
                    ((hold_q[i] > REP_AT) && (rate_q[i] == RATE_LAST)));
      if (db_level[i]) begin
        hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
        if (!rep_hit[i] && (hold_q[i] > REP_AT)) rate_d[i] = rate_q[i] + 1'b1;
      end
    end
  end

  // Saturation parks the middle counter above LONG_CNT, so the long event
  // cannot recur until release clears it.
  always_comb begin
    lhold_d  = '0;
    long_hit = db_level[BTN_MIDDLE] && (lhold_q == LONG_AT);
    if (db_level[BTN_MIDDLE]) lhold_d = (lhold_q == LONG_MAX) ? lhold_q : lhold_q + 1'b1;
  end

  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic [NUM_BTN-1:0] level_q;
  logic               long_q;

  assign pulse_d = db_rise | {{(NUM_BTN-2){1'b0}}, rep_hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= '0;
      rate_q  <= '0;
      lhold_q <= '0;
      pulse_q <= '0;
      level_q <= '0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      rate_q  <= rate_d;
      lhold_q <= lhold_d;
      pulse_q <= pulse_d;
      level_q <= db_level;
      long_q  <= long_hit;
    end
  end

  assign up_pulse     = pulse_q[BTN_UP];
  assign down_pulse   = pulse_q[BTN_DOWN];
  assign left_pulse   = pulse_q[BTN_LEFT];
  assign right_pulse  = pulse_q[BTN_RIGHT];
  assign middle_pulse = pulse_q[BTN_MIDDLE];
  assign middle_long  = long_q;
  assign btn_level    = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short timing parameters: table of single
// press/glitch vectors plus hand sequences for repeat, long press and reset.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int LC = 30;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn   = '0;  // {middle,right,left,down,up}

  logic       up_pulse, down_pulse, left_pulse, right_pulse, middle_pulse;
  logic       middle_long;
  logic [4:0] btn_level;

  always #5 clk = ~clk;

  button_conditioner #(
    .DB_CNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .LONG_CNT(LC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_up    (btn[0]),
    .button_down  (btn[1]),
    .button_left  (btn[2]),
    .button_right (btn[3]),
    .button_middle(btn[4]),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .middle_pulse (middle_pulse),
    .middle_long  (middle_long),
    .btn_level    (btn_level)
  );

  wire [4:0]  pulse = {middle_pulse, right_pulse, left_pulse, down_pulse, up_pulse};
  wire [10:0] obs   = {btn_level, pulse, middle_long};

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] exp_q[$];  // full output snapshots for the vector table
  logic [7:0]  pq[$];     // expected hold counts of press/repeat pulses
  logic [7:0]  lq[$];     // expected hold counts of middle_long

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_evt(input string name, input int c);
    n_chk++;
    $display("FAIL %s: got event at hold count %0d, expected none", name, c);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    btn = '0;
    repeat (n) cycle();
  endtask

  // Presses mask, then watches pulse[idx] and middle_long. After edge k the
  // btn_level-aligned hold count is k-7 (raw sampled at edge 1, level at 7).
  task automatic hold_seq(input string name, input logic [4:0] mask, input int idx,
                          input int rel_k, input int total_k);
    int c;
    btn = btn | mask;
    for (int k = 1; k <= total_k; k++) begin
      cycle();
      c = k - 7;
      if (pulse[idx]) begin
        if (pq.size() == 0) fail_evt({name, "_pulse"}, c);
        else check({name, "_pulse_cnt"}, c, 32'(pq.pop_front()));
      end
      if (middle_long) begin
        if (lq.size() == 0) fail_evt({name, "_long"}, c);
        else check({name, "_long_cnt"}, c, 32'(lq.pop_front()));
      end
      if (k == rel_k) btn = btn & ~mask;
    end
    check({name, "_pulse_missing"}, pq.size(), 0);
    check({name, "_long_missing"}, lq.size(), 0);
    pq.delete();
    lq.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] press;
    int         dur;        // raw high for this many sampling edges (99 = held)
    logic [4:0] exp_level;
    logic [4:0] exp_pulse;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [4:0] rel_seen;

    vecs[0] = '{5'b00100, 99, 5'b00100, 5'b00100};  // left held
    vecs[1] = '{5'b01000,  3, 5'b00000, 5'b00000};  // right 3-cycle glitch
    vecs[2] = '{5'b00011, 99, 5'b00011, 5'b00011};  // up + down together
    vecs[3] = '{5'b10000, 99, 5'b10000, 5'b10000};  // middle held
    vecs[4] = '{5'b01000, 99, 5'b01000, 5'b01000};  // right held
    vecs[5] = '{5'b01000,  4, 5'b01000, 5'b01000};  // right exactly DB_CNT wide
    vecs[6] = '{5'b00100,  2, 5'b00000, 5'b00000};  // left 2-cycle glitch
    vecs[7] = '{5'b11111, 99, 5'b11111, 5'b11111};  // all five together

    // reset state
    cycle();
    cycle();
    check("reset_outputs", obs, 11'd0);
    rst_n = 1'b1;
    idle(5);
    check("post_reset_outputs", obs, 11'd0);

    for (int v = 0; v < 8; v++) begin
      btn = vecs[v].press;
      exp_q.push_back(11'd0);
      exp_q.push_back({vecs[v].exp_level, vecs[v].exp_pulse, 1'b0});
      exp_q.push_back({vecs[v].exp_level, 5'b00000, 1'b0});
      for (int k = 1; k <= 8; k++) begin
        cycle();
        if (k >= 6) check($sformatf("vec%0d_edge%0d", v, k), obs, exp_q.pop_front());
        if (k == vecs[v].dur) btn = '0;
      end
      btn = '0;
      rel_seen = '0;
      for (int k = 0; k < 14; k++) begin
        cycle();
        rel_seen = rel_seen | pulse | {4'b0, middle_long};
      end
      check($sformatf("vec%0d_release_pulse", v), rel_seen, 5'b00000);
      check($sformatf("vec%0d_release_level", v), btn_level, 5'b00000);
    end

    // up auto-repeat; last held count 39, so count 40 must stay quiet
    idle(5);
    pq = '{8'd0, 8'd20, 8'd25, 8'd30, 8'd35};
    hold_seq("up_repeat", 5'b00001, 0, 40, 100);

    // down auto-repeat, released just after the first repeat
    idle(5);
    pq = '{8'd0, 8'd20};
    hold_seq("down_repeat", 5'b00010, 1, 22, 60);

    // middle long press: one press pulse, one long event, no repeats
    idle(5);
    pq = '{8'd0};
    lq = '{8'd30};
    hold_seq("middle_long", 5'b10000, 4, 50, 110);

    // reset in the middle of an up hold at count 22
    idle(5);
    btn = 5'b00001;
    repeat (29) cycle();
    check("pre_reset_level", btn_level, 5'b00001);
    rst_n = 1'b0;
    #1;
    check("reset_async_outputs", obs, 11'd0);
    repeat (3) cycle();
    check("reset_held_outputs", obs, 11'd0);
    rst_n = 1'b1;
    pq = '{8'd0, 8'd20};
    hold_seq("after_reset_up", 5'b00001, 0, 25, 60);

    idle(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DB_CNT, default 20000, number of consecutive stable cycles required to accept a new button level.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50000000, hold cycles before the first auto-repeat pulse on up/down.
REQ-003 SHALL have parameter REPEAT_RATE, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter LONG_CNT, default 100000000, hold cycles before the middle long-press pulse.
REQ-005 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have ports button_up, button_down, button_left, button_right, button_middle, input, 1 each, raw asynchronous push-button levels, active-high.
REQ-008 SHALL have ports up_pulse, down_pulse, left_pulse, right_pulse, middle_pulse, output, 1 each, one-cycle press events, including repeats on up/down.
REQ-009 SHALL have port middle_long, output, 1, one-cycle long-press event.
REQ-010 SHALL have port btn_level, output, 5, debounced levels in order {middle,right,left,down,up}, bit 0 = up.

Function
REQ-011 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep, per button, a debounce counter that clears whenever the synchronized value equals the debounced level and otherwise increments.
REQ-013 SHALL load the synchronized value into the debounced level, and clear the counter, when the counter equals DB_CNT-1 and still mismatches.
REQ-014 SHALL therefore raise btn_level exactly DB_CNT+2 cycles after the first clock edge that samples a raw level which then stays constant; any glitch shorter than DB_CNT cycles SHALL produce no level change.
REQ-015 SHALL assert the button's press pulse for exactly one cycle, in the same cycle its btn_level bit rises; no pulse on release.
REQ-016 SHALL run, for up and down only, a hold counter that is 0 in the cycle btn_level rises, increments each cycle while held, and saturates; it SHALL clear on release.
REQ-017 SHALL emit an extra one-cycle up_pulse/down_pulse when the hold counter equals REPEAT_DELAY, then again every REPEAT_RATE cycles while held.
REQ-018 SHALL emit middle_long once, for one cycle, when the middle hold counter equals LONG_CNT; further holding SHALL produce nothing until release and re-press.
REQ-019 SHALL treat all five buttons independently; simultaneous presses SHALL each produce their own pulses in the same cycle.
REQ-020 SHALL size every counter by $clog2 of its parameter plus one; no counter SHALL wrap.
REQ-021 SHALL have all outputs registered, with no combinational path from raw inputs to outputs.

Reset
REQ-022 SHALL, on rst_n low, immediately clear synchronizers, debounced levels, and all counters; outputs SHALL be 0.
REQ-023 SHALL, for a button held through reset release, produce a normal press pulse DB_CNT+2 cycles after release; a reset asserted mid-hold SHALL cancel pending repeats/long-press.

Structure
REQ-024 SHALL take default parameter values and button index constants (UP=0 ... MIDDLE=4) from shared package clock_btn_pkg.
REQ-025 SHALL instantiate sub-module btn_debounce (synchronizer + debounce + rise pulse) five times; hold/repeat logic stays in the top.

Verification (DB_CNT=4, REPEAT_DELAY=20, REPEAT_RATE=5, LONG_CNT=30)
REQ-026 SHALL check: button_left high at edge 10 and held -> btn_level[2] and left_pulse high at edge 16, left_pulse low at edge 17.
REQ-027 SHALL check: button_right 3-cycle glitch -> no level change, no pulse.
REQ-028 SHALL check: button_up held 40 cycles after level rise -> up_pulse at hold counts 0, 20, 25, 30, 35; none after release.
REQ-029 SHALL check: button_middle held 50 cycles -> middle_pulse at count 0, middle_long exactly once at count 30.
REQ-030 SHALL check: up and down pressed the same cycle -> both pulses in the same cycle.
REQ-031 SHALL check: rst_n low during up hold at count 22 -> all outputs 0 at once; after release, new up_pulse 6 cycles later.
